alu_result_tx: RTL and testbench

ALU_RESULT_TX -- requirements
Module: alu_result_tx

---
 rtl/alu_result_tx.sv | 193 +++++++++++++++++++
 tb/tb_alu_result_tx.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_tx.sv
// ============================================================================
// Module   : alu_result_tx
// Purpose  : Buffers ALU results ({carry, byte}) in a small FIFO and sends each
//            one as a serial frame: start(0), 8 data bits LSB first, carry,
//            optional even parity, stop(1). The line idles at 1.
// Options  : `define ALU_RESULT_TX_PARITY_EN adds the PARITY bit (12-bit frame);
//            when it is not defined the frame is 11 bits (CARRY -> STOP).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_result_tx #(
  parameter int BAUD_DIV   = 4,  // clock cycles per serial bit, 2..255
  parameter int FIFO_DEPTH = 4   // power of two, 2..16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_carry,
  output logic       tx_line,
  output logic       tx_busy,
  output logic [4:0] fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    CARRY  = 3'd3,
`ifdef ALU_RESULT_TX_PARITY_EN
    PARITY = 3'd4,
`endif
    STOP   = 3'd5
  } state_t;

  // --------------------------------------------------------------------------
  // Result FIFO
  // --------------------------------------------------------------------------
  logic [8:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [4:0]       count;
  logic             push;
  logic             pop;

  // Ready depends only on the registered count, so a pop in the same cycle
  // never lets an extra entry in.
  assign in_ready   = (count < 5'(FIFO_DEPTH));
  assign push       = in_valid && in_ready;
  assign fifo_count = count;

  // Pointer and occupancy bookkeeping; pointers wrap naturally (power of two).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + 5'd1;
      else if (pop && !push) count <= count - 5'd1;
    end
  end

  // Storage array; stale contents are harmless because the pointers reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_carry, in_data};
  end

  // --------------------------------------------------------------------------
  // Frame sequencer
  // --------------------------------------------------------------------------
  state_t     state;
  state_t     state_next;
  logic [7:0] cnt;
  logic [7:0] cnt_next;
  logic [2:0] bit_idx;
  logic [2:0] bit_next;
  logic [7:0] frame_data;
  logic       frame_carry;
  logic       tx_next;
  logic       bit_end;

  assign bit_end = (cnt == 8'(BAUD_DIV - 1));
  assign tx_busy = (state != IDLE);

  // Next-state, bit-period counter and registered line value for the new state.
  always_comb begin
    state_next = state;
    cnt_next   = cnt + 8'd1;
    bit_next   = bit_idx;
    pop        = 1'b0;
    tx_next    = 1'b1;

    case (state)
      IDLE: begin
        cnt_next = '0;
        if (count != 5'd0) begin
          pop        = 1'b1;
          state_next = START;
        end
      end
      START: begin
        if (bit_end) begin
          state_next = DATA;
          cnt_next   = '0;
          bit_next   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_next = '0;
          if (bit_idx == 3'd7) state_next = CARRY;
          else                 bit_next   = bit_idx + 3'd1;
        end
      end
      CARRY: begin
        if (bit_end) begin
          cnt_next   = '0;
`ifdef ALU_RESULT_TX_PARITY_EN
          state_next = PARITY;
`else
          state_next = STOP;
`endif
        end
      end
`ifdef ALU_RESULT_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          cnt_next   = '0;
          state_next = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          cnt_next   = '0;
          state_next = IDLE;
        end
      end
      default: begin
        cnt_next   = '0;
        state_next = IDLE;
      end
    endcase

    // The line value follows the state being entered, so it appears on the
    // same edge as the state change. START is entered before the byte is in
    // frame_data, but START always drives 0 so that does not matter.
    case (state_next)
      START:  tx_next = 1'b0;
      DATA:   tx_next = frame_data[bit_next];
      CARRY:  tx_next = frame_carry;
`ifdef ALU_RESULT_TX_PARITY_EN
      PARITY: tx_next = ^{frame_carry, frame_data};
`endif
      default: tx_next = 1'b1;
    endcase
  end

  // State register, bit-period counter, bit index and line register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      tx_line <= 1'b1;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      bit_idx <= bit_next;
      tx_line <= tx_next;
    end
  end

  // Capture the FIFO head when a frame is launched.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_data  <= '0;
      frame_carry <= 1'b0;
    end else if (pop) begin
      {frame_carry, frame_data} <= mem[rd_ptr];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_result_tx.sv
// ============================================================================
// Module   : tb_alu_result_tx
// Purpose  : Directed bench for alu_result_tx (BAUD_DIV=4, FIFO_DEPTH=4).
//            Frame length follows `ALU_RESULT_TX_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_result_tx;

`ifdef ALU_RESULT_TX_PARITY_EN
  localparam int NB = 12;
`else
  localparam int NB = 11;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = '0;
  logic       in_carry = 1'b0;
  logic       tx_line;
  logic       tx_busy;
  logic [4:0] fifo_count;

  int vec_cnt = 0;
  int err_cnt = 0;

  alu_result_tx #(.BAUD_DIV(4), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_carry   (in_carry),
    .tx_line    (tx_line),
    .tx_busy    (tx_busy),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bit i of the result is the i-th bit on the line.
  function automatic logic [11:0] exp_frame(input logic [8:0] e);
`ifdef ALU_RESULT_TX_PARITY_EN
    return {1'b1, ^e, e[8], e[7:0], 1'b0};
`else
    return {1'b0, 1'b1, e[8], e[7:0], 1'b0};
`endif
  endfunction

  task automatic wait_start(output int gap, output bit to);
    gap = 0;
    to  = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx_line === 1'b0) begin
        to = 1'b0;
        break;
      end
      gap++;
    end
  endtask

  // Called at the first negedge of START; returns at the last negedge of STOP.
  task automatic rx_frame(output logic [11:0] bits, output bit stable);
    bits   = '0;
    stable = 1'b1;
    for (int j = 0; j < NB * 4; j++) begin
      if (j > 0) @(negedge clk);
      if (j % 4 == 0)                 bits[j/4] = tx_line;
      else if (tx_line !== bits[j/4]) stable = 1'b0;
      if (tx_busy !== 1'b1)           stable = 1'b0;
    end
  endtask

  task automatic rx_checked(input string tag, input logic [8:0] e, input bit chk_gap);
    int gap;
    bit to;
    bit st;
    logic [11:0] bits;
    wait_start(gap, to);
    check({tag, "_timeout"}, 32'(to), 32'd0);
    if (!to) begin
      if (chk_gap) check({tag, "_gap"}, 32'(gap), 32'd1);
      rx_frame(bits, st);
      check({tag, "_frame"}, 32'(bits), 32'(exp_frame(e)));
      check({tag, "_hold"}, 32'(st), 32'd1);
    end
  endtask

  task automatic send_one(input string tag, input logic [7:0] d, input logic c,
                          output logic [11:0] bits);
    bit st;
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_carry = c;
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, "_cnt1"}, 32'(fifo_count), 32'd1);
    check({tag, "_idle1"}, 32'(tx_line), 32'd1);
    @(negedge clk);
    check({tag, "_lat"}, 32'(tx_line), 32'd0);
    check({tag, "_busy"}, 32'(tx_busy), 32'd1);
    check({tag, "_cnt0"}, 32'(fifo_count), 32'd0);
    rx_frame(bits, st);
    check({tag, "_frame"}, 32'(bits), 32'(exp_frame({c, d})));
    check({tag, "_hold"}, 32'(st), 32'd1);
    @(negedge clk);
    check({tag, "_end"}, 32'({tx_line, tx_busy}), 32'b10);
  endtask

  logic [8:0] bd [0:5] = '{9'h111, 9'h022, 9'h13C, 9'h080, 9'h17E, 9'h099};
  logic [8:0] rd [0:2] = '{9'h0F0, 9'h155, 9'h1AA};
  localparam logic [8:0] HOLD = 9'h1C3;

  initial begin
    logic [11:0] b;
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_tx", 32'(tx_line), 32'd1);
    check("rst_busy", 32'(tx_busy), 32'd0);
    check("rst_cnt", 32'(fifo_count), 32'd0);
    check("rst_rdy", 32'(in_ready), 32'd1);
    rst_n = 1'b1;

    // Single frames with hand-computed line patterns
    send_one("a5", 8'hA5, 1'b1, b);
`ifdef ALU_RESULT_TX_PARITY_EN
    check("a5_const", 32'(b), 32'h0F4A);
`else
    check("a5_const", 32'(b), 32'h074A);
`endif
    send_one("z", 8'h00, 1'b0, b);
    check("z_data", 32'(b[8:1]), 32'd0);
`ifdef ALU_RESULT_TX_PARITY_EN
    check("z_par", 32'(b[10]), 32'd0);
`endif
    send_one("ff", 8'hFF, 1'b0, b);
`ifdef ALU_RESULT_TX_PARITY_EN
    check("ff_par", 32'(b[10]), 32'd0);
`endif
    send_one("01", 8'h01, 1'b0, b);
`ifdef ALU_RESULT_TX_PARITY_EN
    check("01_par", 32'(b[10]), 32'd1);
`endif

    // Burst of 6 while idle, then a held push across the pop edge
    fork
      begin
        bit seen;
        for (int i = 0; i < 6; i++) begin
          @(negedge clk);
          in_valid = 1'b1;
          {in_carry, in_data} = bd[i];
        end
        @(negedge clk);
        check("full_rdy", 32'(in_ready), 32'd0);
        check("full_cnt", 32'(fifo_count), 32'd4);
        {in_carry, in_data} = HOLD;
        seen = 1'b0;
        for (int k = 0; k < 200; k++) begin
          @(negedge clk);
          if (tx_busy === 1'b0) begin
            seen = 1'b1;
            break;
          end
        end
        check("idle_seen", 32'(seen), 32'd1);
        check("idle_cnt", 32'(fifo_count), 32'd4);
        @(negedge clk);
        check("pop_rej", 32'(fifo_count), 32'd3);
        @(negedge clk);
        check("push_next", 32'(fifo_count), 32'd4);
        in_valid = 1'b0;
      end
      begin
        for (int f = 0; f < 6; f++)
          rx_checked($sformatf("burst%0d", f), (f < 5) ? bd[f] : HOLD, f > 0);
      end
    join
    @(negedge clk);
    check("drain_cnt", 32'(fifo_count), 32'd0);

    // Reset during DATA of the second of three queued frames
    fork
      begin
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          in_valid = 1'b1;
          {in_carry, in_data} = rd[i];
        end
        @(negedge clk);
        in_valid = 1'b0;
      end
      begin
        int gap;
        bit to;
        int bad;
        rx_checked("rq0", rd[0], 1'b0);
        wait_start(gap, to);
        check("rq1_timeout", 32'(to), 32'd0);
        check("rq1_gap", 32'(gap), 32'd1);
        check("pre_rst_cnt", 32'(fifo_count), 32'd1);
        repeat (7) @(negedge clk);
        check("pre_rst_busy", 32'(tx_busy), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_tx", 32'(tx_line), 32'd1);
        check("mid_rst_cnt", 32'(fifo_count), 32'd0);
        check("mid_rst_busy", 32'(tx_busy), 32'd0);
        check("mid_rst_rdy", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        bad = 0;
        repeat (120) begin
          @(negedge clk);
          if (tx_line !== 1'b1 || tx_busy !== 1'b0) bad++;
        end
        check("no_more_frames", 32'(bad), 32'd0);
      end
    join

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
